fb_swap_arbiter: RTL
====================

# fb_swap_arbiter

Double-buffered frame-buffer controller between the animation renderer (writer) and the frame reader (scan-out). It shares one single-port point memory holding two frame banks between both requesters and grants scan reads priority with bounded writer starvation. It swaps the front and back banks only at a scan-frame boundary after the renderer declares the back frame complete, so the display matrix never shows a torn frame.

## Interface
Parameters:
- ADDR_WIDTH, 8, point address width; one bank holds 2^ADDR_WIDTH points
- DATA_WIDTH, 1, bits per point
- STARVE_LIMIT, 15, consecutive denied writer cycles before the writer is forced through; range 1..255

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- rd_req  in  1  scan read request; held with rd_addr until rd_gnt
- rd_addr  in  ADDR_WIDTH  point address in front bank
- rd_frame_end  in  1  marks the request as the last point of a scan frame; qualified by rd_gnt
- rd_gnt  out  1  read issued this cycle (combinational)
- rd_valid  out  1  rd_data valid; registered, one cycle after rd_gnt
- rd_data  out  DATA_WIDTH  equals mem_rdata; meaningful only when rd_valid=1
- wr_req  in  1  renderer write request; held with wr_addr and wr_data until wr_ack
- wr_addr  in  ADDR_WIDTH  point address in back bank
- wr_data  in  DATA_WIDTH  point value
- wr_ack  out  1  write issued this cycle (combinational)
- wr_done  in  1  single-cycle pulse: back frame complete
- wr_ready  out  1  back bank open for writing
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH+1  {bank, point}
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  memory read data; fixed one-cycle latency
- front_bank  out  1  bank currently scanned
- swap_count  out  8  completed swaps; wraps 255->0

## Operation
- Arbitration, evaluated each cycle:
  - write_elig = wr_req & wr_ready.
  - If write_elig and starve_cnt == STARVE_LIMIT: writer wins.
  - Otherwise, if rd_req: reader wins.
  - Otherwise, if write_elig: writer wins.
  - Otherwise: idle.
- Read grant: mem_en=1, mem_we=0, mem_addr={front_bank, rd_addr}, rd_gnt=1.
- Write grant: mem_en=1, mem_we=1, mem_addr={~front_bank, wr_addr}, mem_wdata=wr_data, wr_ack=1.
- Idle: mem_en=0, mem_we=0.
- rd_gnt and wr_ack are never high in the same cycle.
- starve_cnt (8 bits) behaviour:
  - Increments when write_elig is high and the writer loses.
  - Clears on wr_ack or when write_elig is low.
  - Saturates at STARVE_LIMIT.
- Swap FSM, two states:
  - OPEN (wr_ready=1): wr_done -> PENDING.
  - PENDING (wr_ready=0): when rd_gnt & rd_frame_end, toggle front_bank, increment swap_count, and go -> OPEN.
- Simultaneous wr_done and rd_gnt & rd_frame_end while in OPEN: go to PENDING only. That frame end does not swap; the swap waits for the next full frame end.
- Write granted in the same cycle as wr_done: the write is performed; wr_ready drops the following cycle.
- wr_req while wr_ready=0: no ack, no memory access, starve_cnt held at 0.
- wr_done in PENDING is ignored.
- A read granted in the swap cycle uses the old front_bank. The swap takes effect for grants from the next cycle.

## Timing
- Reset values: front_bank=0, swap_count=0, FSM=OPEN (wr_ready=1), rd_valid=0, starve_cnt=0.
- Combinational outputs with no request present after reset: rd_gnt=0, wr_ack=0, mem_en=0.
- Reset asserted mid-operation: a pending swap is discarded, and any read in flight produces no rd_valid.
- Read latency: rd_gnt at cycle N gives rd_valid=1 at N+1, with rd_data=mem_rdata.
- Back-to-back read grants give continuous rd_valid.
- Worst-case writer wait with rd_req held high: STARVE_LIMIT+1 cycles from the first eligible cycle to wr_ack.
- Worst-case reader wait: 1 cycle.
- Swap latency: front_bank changes on the clock edge ending the qualifying frame-end grant cycle.
- swap_count updates on the same edge as front_bank.

## Test plan
- Reset then single read: preload mem[{0,0x12}]=1; assert rd_req with rd_addr=0x12 -> rd_gnt the same cycle, mem_addr=0x012, rd_valid=1 and rd_data=1 the next cycle.
- Reader priority: rd_req and wr_req both high with wr_addr=0x05 -> rd_gnt first. With rd_req dropped next cycle -> wr_ack, mem_we=1, mem_addr=0x105.
- Starvation bound: rd_req held high continuously, STARVE_LIMIT=15, wr_req held high -> wr_ack exactly 16 cycles after wr_req rises, with rd_gnt=0 in that cycle.
- Swap sequence: write a full back frame, pulse wr_done -> wr_ready=0 next cycle. A later read with rd_frame_end -> front_bank=1, swap_count=1, wr_ready=1. The next read addresses 0x1xx.
- Simultaneous events: wr_done in the same cycle as a frame-end read grant -> no swap and front_bank unchanged; the following frame end swaps.
- Reset mid-PENDING: wr_done, then reset before frame end -> front_bank=0, swap_count=0, wr_ready=1, rd_valid=0.

Source files
------------

// File: rtl/fb_swap_arbiter.sv
// Double-buffered frame-buffer arbiter. Grants are same-cycle and read data arrives 1 cycle later.
// Scan reads win over writes, except when a writer has been denied STARVE_LIMIT times; banks swap only at a frame end.
module fb_swap_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_frame_end,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  wr_done,
    output logic                  wr_ready,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  front_bank,
    output logic [7:0]            swap_count
);

    typedef enum logic {
        OPEN    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    typedef struct packed {
        logic                  bank;
        logic [ADDR_WIDTH-1:0] point;
    } mem_addr_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    swap_state_t state;
    logic [7:0]  starve_cnt;
    logic        write_elig;
    logic        force_wr;
    logic        grant_rd;
    logic        grant_wr;
    mem_addr_t   addr_sel;

    always_comb begin
        write_elig = wr_req & wr_ready;
        force_wr   = write_elig && (starve_cnt == STARVE_MAX);
        grant_rd   = rd_req && !force_wr;
        grant_wr   = write_elig && !grant_rd;
    end

    // Reads target the front bank, writes the back bank; front_bank only moves after the grant cycle.
    always_comb begin
        addr_sel.bank  = grant_wr ? ~front_bank : front_bank;
        addr_sel.point = grant_wr ? wr_addr : rd_addr;
    end

    assign rd_gnt    = grant_rd;
    assign wr_ack    = grant_wr;
    assign mem_en    = grant_rd | grant_wr;
    assign mem_we    = grant_wr;
    assign mem_addr  = addr_sel;
    assign mem_wdata = grant_wr ? wr_data : '0;
    assign rd_data   = mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!write_elig || grant_wr) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= grant_rd;
        end
    end

    // A frame end coinciding with wr_done is not a swap point: the frame being scanned started before the back frame was complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= OPEN;
            wr_ready   <= 1'b1;
            front_bank <= 1'b0;
            swap_count <= 8'd0;
        end else begin
            case (state)
                OPEN: begin
                    if (wr_done) begin
                        state    <= PENDING;
                        wr_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (grant_rd && rd_frame_end) begin
                        state      <= OPEN;
                        wr_ready   <= 1'b1;
                        front_bank <= ~front_bank;
                        swap_count <= swap_count + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
